seq_detect_ctrl: RTL and testbench
==================================

# seq_detect_ctrl

Run controller for the serial sequence detectors. It takes a pattern configuration through a valid/ready handshake, then arms and runs a programmable overlapping or non-overlapping detector on the serial bit `x`. It counts matches and stops after a programmed target. It sits between the stimulus/config side and the downstream consumer of the detect pulse `y`, and generalises the fixed-1011 Moore/Mealy detectors into one sequenced, reusable block.

## Interface
- `W`, default 8: maximum pattern length in bits.
- `CNT_W`, default 8: width of the match counter and the target.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `cfg_valid`, input, 1: configuration offered.
- `cfg_ready`, output, 1: configuration accepted this cycle when `cfg_valid` is also high. High only in IDLE.
- `cfg_pattern`, input, W: pattern. Bit `len-1` is the first serial bit; bit 0 is the last.
- `cfg_len`, input, $clog2(W+1): pattern length. Legal range is 1..W.
- `cfg_overlap`, input, 1: 1 = overlapping detection, 0 = history is discarded after each match.
- `cfg_target`, input, CNT_W: number of matches before DONE. 0 means run until aborted.
- `start`, input, 1: arm and enter RUN from READY.
- `abort`, input, 1: return to IDLE from any state.
- `clear`, input, 1: DONE -> READY, keeping the configuration.
- `x_valid`, input, 1: `x` is a valid stream bit this cycle.
- `x`, input, 1: serial data bit.
- `y`, output, 1: one-cycle registered detect pulse.
- `match_count`, output, CNT_W: matches since the last `start`.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: high in DONE.
- `cfg_err`, output, 1: one-cycle pulse when an illegal configuration is rejected.

## Operation
- States are IDLE, READY, RUN and DONE. Reset puts the block in IDLE.
- Priority is `abort` above all else, then the per-state rules below.
- **IDLE**
  - `cfg_ready`=1.
  - If `cfg_valid` with `cfg_len` in 1..W: latch pattern, len, overlap and target, then go to READY.
  - If `cfg_valid` with `cfg_len`=0 or >W: pulse `cfg_err` next cycle and stay in IDLE.
- **READY**
  - `start` clears the shift register, `bits_seen` and `match_count`, then goes to RUN.
- **RUN**, on each `x_valid` cycle:
  - Next shift register is `{sr[W-2:0], x}`.
  - Next `bits_seen` is `min(bits_seen+1, len)`.
  - A match occurs when next `bits_seen` == len and the low `len` bits of the next shift register equal the low `len` bits of the pattern.
- **On a match**
  - `y`=1 in the following cycle.
  - `match_count` increments, saturating at all-ones.
  - If `cfg_overlap`=0, `bits_seen` is forced to 0.
  - If target ≠ 0 and the incremented count == target, go to DONE.
- Cycles with `x_valid`=0 change nothing in RUN.
- **DONE**
  - `x_valid` is ignored.
  - `clear` goes to READY.
  - `start` in DONE is ignored.
- Ignored inputs:
  - `start` is ignored outside READY.
  - `clear` is ignored outside DONE.
  - `cfg_valid` is ignored outside IDLE.
- **abort**
  - From any state, go to IDLE on the next edge.
  - `y` is suppressed that cycle.
  - `match_count` keeps its value.
- **Reset values**
  - `cfg_ready`=1; `y`, `busy`, `done` and `cfg_err` are 0.
  - `match_count`=0; shift register and `bits_seen` are 0.
  - Configuration registers are 0.
- **Reset mid-run** returns to IDLE immediately (asynchronous); the configuration is lost.

## Timing
- Match latency: the edge that samples the completing bit also registers `y`. `y` is high for exactly the next cycle, and `match_count` updates on that same edge.
- DONE entry: `done` rises on the same edge as the final `y`; `busy` falls on that edge.
- Configuration: handshake completes on the edge where `cfg_valid` and `cfg_ready` are both high. READY is visible next cycle, and `start` is accepted from that cycle.
- `start` -> `busy`: 1 cycle. The first stream bit is accepted in the cycle after `start` registers.
- Back-to-back matches are supported on consecutive `x_valid` cycles in overlap mode with len=1, giving `y` high continuously.

## Structure
- Package `seq_detect_pkg` holds:
  - state enum `{IDLE, READY, RUN, DONE}`;
  - default `W` and `CNT_W`;
  - the length-width function `$clog2(W+1)`.
- One natural sub-module, `seq_match_core`, contains the shift register, `bits_seen`, masked compare and match output. The controller FSM, counter and handshake stay in `seq_detect_ctrl`.

## Test plan
- **Overlap 1011:** cfg pattern=4'b1011, len=4, overlap=1, target=0; stream 1,0,1,1,0,1,1 -> `y` pulses after bits 4 and 7; `match_count`=2.
- **Non-overlap:** same stream with overlap=0 -> single `y` after bit 4; `match_count`=1.
- **Target stop:** target=2 on stream 1011011011 -> `done` after the second match; further `x` leaves count at 2; `clear` -> READY; `start` clears count to 0.
- **Illegal config:** cfg_len=0, then cfg_len=9 with W=8 -> `cfg_err` pulses twice, stays IDLE, `cfg_ready` stays 1.
- **Gaps and abort:** 1011 with `x_valid` low between bits -> match is still detected; `abort` mid-stream -> IDLE next cycle, no `y`, count held.
- **Async reset mid-run:** `reset` low between clock edges -> all outputs at reset values immediately; a new config is required before `start` is honoured.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and sizing helpers for the serial sequence detector run controller.
package seq_detect_pkg;

  localparam int unsigned DEF_W     = 8;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed to hold a pattern length in 0..w.
  function automatic int unsigned len_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: history shift register, fill counter and masked compare.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned LEN_W = len_width(DEF_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             x,
  input  logic [W-1:0]     pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             match
);

  logic [W-1:0]     sr;
  logic [W-1:0]     sr_nxt;
  logic [W-1:0]     mask;
  logic [LEN_W-1:0] bits_seen;
  logic [LEN_W-1:0] seen_nxt;
  logic             cmp_eq;

  // Comparing before incrementing keeps the fill count from wrapping when W+1 is a power of two.
  always_comb begin
    sr_nxt   = W'({sr, x});
    seen_nxt = (bits_seen < len) ? bits_seen + LEN_W'(1) : len;
    for (int i = 0; i < W; i++) begin
      mask[i] = (i < int'(len));
    end
    cmp_eq = (((sr_nxt ^ pattern) & mask) == '0);
    match  = en && (seen_nxt == len) && cmp_eq;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      sr        <= '0;
      bits_seen <= '0;
    end else if (clr) begin
      sr        <= '0;
      bits_seen <= '0;
    end else if (en) begin
      sr        <= sr_nxt;
      bits_seen <= (match && !overlap) ? '0 : seen_nxt;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: config handshake, IDLE/READY/RUN/DONE sequencing, match counting and detect pulse.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [W-1:0]            cfg_pattern,
  input  logic [len_width(W)-1:0] cfg_len,
  input  logic                    cfg_overlap,
  input  logic [CNT_W-1:0]        cfg_target,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    clear,
  input  logic                    x_valid,
  input  logic                    x,
  output logic                    y,
  output logic [CNT_W-1:0]        match_count,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  localparam int unsigned LEN_W = len_width(W);

  state_t           state;
  state_t           state_nxt;

  logic [W-1:0]     pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] tgt_q;

  logic             cfg_legal;
  logic             cfg_accept;
  logic             cfg_reject;
  logic             run_start;
  logic             bit_en;
  logic             match;
  logic [CNT_W-1:0] cnt_inc;
  logic             target_hit;

  // Abort outranks every per-state action, so it gates all the strobes below.
  always_comb begin
    cfg_legal  = (cfg_len != '0) && (32'(cfg_len) <= W);
    cfg_accept = (state == IDLE) && cfg_valid && cfg_legal && !abort;
    cfg_reject = (state == IDLE) && cfg_valid && !cfg_legal && !abort;
    run_start  = (state == READY) && start && !abort;
    bit_en     = (state == RUN) && x_valid && !abort;
    cnt_inc    = (match_count == '1) ? match_count : match_count + CNT_W'(1);
    target_hit = match && (tgt_q != '0) && (cnt_inc == tgt_q);
  end

  seq_match_core #(
    .W     (W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .clr     (run_start),
    .en      (bit_en),
    .x       (x),
    .pattern (pat_q),
    .len     (len_q),
    .overlap (ovl_q),
    .match   (match)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (cfg_accept) state_nxt = READY;
        READY:   if (start)      state_nxt = RUN;
        RUN:     if (target_hit) state_nxt = DONE;
        DONE:    if (clear)      state_nxt = READY;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:    cfg_ready = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    done      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: configuration registers are reset too, so an asynchronous reset forces a fresh config.
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      tgt_q <= '0;
    end else if (cfg_accept) begin
      pat_q <= cfg_pattern;
      len_q <= cfg_len;
      ovl_q <= cfg_overlap;
      tgt_q <= cfg_target;
    end
  end

  // The count survives abort; only start or reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
      y           <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      y       <= match;
      cfg_err <= cfg_reject;
      if (run_start)  match_count <= '0;
      else if (match) match_count <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: directed streams push expected counts, a monitor checks each y pulse.
module tb_seq_detect_ctrl;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [W-1:0]     cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             abort;
  logic             clear;
  logic             x_valid;
  logic             x;
  logic             y;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;
  logic             cfg_err;

  int               n_vec;
  int               n_err;
  int               cnt_model;
  logic [CNT_W-1:0] exp_q[$];

  seq_detect_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .clear       (clear),
    .x_valid     (x_valid),
    .x           (x),
    .y           (y),
    .match_count (match_count),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every y pulse must correspond to a queued expected match, carrying the count it produced.
  always @(negedge clk) begin
    if (reset && y) begin
      if (exp_q.size() == 0) begin
        check("y_unexpected", 32'(y), 32'd0);
      end else begin
        check("y_count", 32'(match_count), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [W-1:0] pat, input logic [3:0] len,
                           input logic ovl, input logic [CNT_W-1:0] tgt);
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_target  = tgt;
    tick();
    cfg_valid = 1'b0;
    check("cfg_accepted", 32'(cfg_ready), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start     = 1'b0;
    cnt_model = 0;
    check("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Bits go out MSB first; a set bit in mmask marks a bit expected to complete a match.
  task automatic send_stream(input logic [15:0] bits, input int n,
                             input logic [15:0] mmask, input logic gap);
    for (int i = n - 1; i >= 0; i--) begin
      x_valid = 1'b1;
      x       = bits[i];
      if (mmask[i]) begin
        cnt_model++;
        exp_q.push_back(CNT_W'(cnt_model));
      end
      tick();
      x_valid = 1'b0;
      if (gap) tick();
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cnt_model = 0;
    cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cfg_target = '0;
    start = 0; abort = 0; clear = 0; x_valid = 0; x = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_outputs", {28'd0, y, busy, done, cfg_err}, 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    #5 reset = 1'b1;
    tick();

    // Overlapping 1011 on 1011011: matches after bits 4 and 7.
    configure(8'b1011, 4'd4, 1'b1, 8'd0);
    do_start();
    send_stream(16'b1011011, 7, 16'b0001001, 1'b0);
    tick();
    check("ovl_count", 32'(match_count), 32'd2);
    do_abort();
    check("ovl_abort_idle", 32'(cfg_ready), 32'd1);
    check("ovl_abort_held", 32'(match_count), 32'd2);

    // Non-overlapping: the second 1011 shares its leading 1 with the first, so only one match.
    configure(8'b1011, 4'd4, 1'b0, 8'd0);
    do_start();
    check("start_clears", 32'(match_count), 32'd0);
    send_stream(16'b1011011, 7, 16'b0001000, 1'b0);
    tick();
    check("novl_count", 32'(match_count), 32'd1);
    do_abort();

    // Target of 2: DONE on the same edge as the second y, later bits ignored.
    configure(8'b1011, 4'd4, 1'b1, 8'd2);
    do_start();
    send_stream(16'b1011011, 7, 16'b0001001, 1'b0);
    check("tgt_done", {30'd0, done, busy}, 32'd2);
    send_stream(16'b011, 3, 16'b000, 1'b0);
    check("tgt_count_held", 32'(match_count), 32'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_ignores_start", {30'd0, done, busy}, 32'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_ready", {29'd0, cfg_ready, done, busy}, 32'd0);
    do_start();
    check("restart_count", 32'(match_count), 32'd0);
    do_abort();

    // Illegal lengths 0 and W+1 are rejected with a one-cycle cfg_err.
    for (int k = 0; k < 2; k++) begin
      cfg_valid = 1'b1;
      cfg_len   = (k == 0) ? 4'd0 : 4'd9;
      tick();
      cfg_valid = 1'b0;
      check("bad_cfg_err", {30'd0, cfg_err, cfg_ready}, 32'd3);
      tick();
      check("bad_cfg_pulse", {30'd0, cfg_err, cfg_ready}, 32'd1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_ignores_start", {30'd0, busy, cfg_ready}, 32'd1);

    // Gaps between valid bits still match; abort with the completing bit suppresses y.
    configure(8'b1011, 4'd4, 1'b1, 8'd0);
    do_start();
    send_stream(16'b1011, 4, 16'b0001, 1'b1);
    send_stream(16'b101, 3, 16'b000, 1'b0);
    x_valid = 1'b1;
    x       = 1'b1;
    abort   = 1'b1;
    tick();
    x_valid = 1'b0;
    abort   = 1'b0;
    check("abort_idle", {30'd0, cfg_ready, busy}, 32'd2);
    check("abort_no_y", 32'(y), 32'd0);
    check("abort_held", 32'(match_count), 32'd1);

    // Full-width pattern, non-overlap, target 1.
    configure(8'hA5, 4'd8, 1'b0, 8'd1);
    do_start();
    send_stream(16'h00A5, 8, 16'h0001, 1'b0);
    check("len8_done", {30'd0, done, busy}, 32'd2);
    do_abort();

    // len=1 overlap: y held high on consecutive bits; count saturates at all-ones.
    configure(8'h01, 4'd1, 1'b1, 8'd0);
    do_start();
    for (int i = 0; i < 260; i++) begin
      x_valid = 1'b1;
      x       = 1'b1;
      cnt_model = (cnt_model < 255) ? cnt_model + 1 : 255;
      exp_q.push_back(CNT_W'(cnt_model));
      tick();
      if (i == 2) check("b2b_y_high", 32'(y), 32'd1);
    end
    x_valid = 1'b0;
    tick();
    check("sat_count", 32'(match_count), 32'd255);
    do_abort();

    // Asynchronous reset between edges clears everything and forgets the config.
    configure(8'b1011, 4'd4, 1'b1, 8'd0);
    do_start();
    send_stream(16'b1011, 4, 16'b0001, 1'b0);
    tick();
    #3 reset = 1'b0;
    #1;
    check("arst_count", 32'(match_count), 32'd0);
    check("arst_flags", {28'd0, cfg_ready, busy, done, y}, 32'd8);
    reset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("arst_needs_cfg", {30'd0, cfg_ready, busy}, 32'd2);
    configure(8'b1011, 4'd4, 1'b1, 8'd0);
    do_start();
    do_abort();

    repeat (3) tick();
    check("pending_y", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
